motion_detector: RTL and testbench
==================================

MOTION_DETECTOR -- requirements
Module: motion_detector

Interface
REQ-001 Parameter THRESH, default 16'd64: magnitude strictly above this counts as motion.
REQ-002 Parameter SETTLE_SAMPLES, default 4: consecutive quiet samples required to leave motion; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 10_000_000: cycles without an accepted sample before the detector drops to IDLE (0.1 s at 100 MHz); legal range 1..2^24-1.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-006 sample_valid  in  1  producer has a sample on sample_x/sample_y.
REQ-007 sample_x  in  16  signed two's-complement X-axis sample.
REQ-008 sample_y  in  16  signed two's-complement Y-axis sample.
REQ-009 sample_ready  out  1  detector can accept a sample this cycle.
REQ-010 value  out  16  unsigned motion magnitude of the most recent evaluated sample.
REQ-011 moving  out  1  motion flag; drives the seven-segment driver's moving input.
REQ-012 value_valid  out  1  one-cycle pulse when value/moving have been updated.

Function
REQ-013 A sample SHALL be accepted only in a cycle where sample_valid=1 and sample_ready=1.
REQ-014 sample_ready SHALL be 0 in the cycle after each acceptance and 1 otherwise, giving at most one sample per 2 cycles.
REQ-015 FSM states SHALL be IDLE (no baseline), STILL, MOVING and SETTLING; reset state is IDLE.
REQ-016 IDLE: an accepted sample SHALL be stored as the baseline (prev_x/prev_y), the FSM SHALL go to STILL, and no value_valid pulse SHALL be produced.
REQ-017 Other states: each accepted sample SHALL be evaluated and then replace the baseline.
- dx = |sample_x - prev_x|, computed at 17 bits and saturated to 16'hFFFF; dy likewise.
- mag = dx + dy, saturated to 16'hFFFF.
REQ-018 Latency: for a sample accepted at edge N, dx/dy SHALL be registered at N+1; value, moving and the FSM state SHALL update at N+2, and value_valid SHALL be 1 for exactly the cycle following edge N+2.
REQ-019 STILL: mag > THRESH -> MOVING; otherwise stay in STILL.
REQ-020 MOVING: mag <= THRESH -> SETTLING with quiet_cnt=1; mag > THRESH -> stay in MOVING.
REQ-021 SETTLING: mag > THRESH -> MOVING with quiet_cnt=0; mag <= THRESH -> quiet_cnt+1, and when the incremented count equals SETTLE_SAMPLES -> STILL with quiet_cnt=0.
REQ-022 SETTLE_SAMPLES=1 SHALL make MOVING go directly to STILL on the first quiet sample.
REQ-023 moving SHALL be 1 in MOVING and SETTLING, and 0 in IDLE and STILL.
REQ-024 mag equal to THRESH SHALL count as quiet.
REQ-025 Idle counter (24 bit) SHALL clear on every acceptance and increment otherwise, saturating at TIMEOUT.
REQ-026 When the idle counter reaches TIMEOUT with the FSM not in IDLE, the FSM SHALL go to IDLE on the next edge.
- moving=0, quiet_cnt=0; value holds; no value_valid pulse.
- If that edge coincides with an acceptance, the acceptance SHALL win: the counter clears and no timeout occurs.
REQ-027 A sample still in the pipeline when a timeout fires SHALL be discarded; no value_valid pulse.
REQ-028 The idle counter SHALL run in every state; in IDLE it has no effect.

Reset
REQ-029 While rst=0, outputs SHALL read sample_ready=1, value=16'h0000, moving=0, value_valid=0.
REQ-030 While rst=0, internal state SHALL be: FSM=IDLE, baseline=0, quiet_cnt=0, idle counter=0, pipeline empty.
REQ-031 Reset assertion SHALL take effect immediately and without a clock edge, including mid-pipeline; an in-flight sample SHALL be lost.
REQ-032 Deassertion SHALL be clean; the first acceptance after release SHALL be treated as a baseline per REQ-016.

Verification
REQ-033 Baseline: after reset, accept (100,100) -> no value_valid pulse, state STILL, moving=0.
REQ-034 Trigger: baseline (0,0), then accept (50,20) -> 2 cycles later value=70, value_valid pulses, moving=1; then accept (50,20) -> value=0, state SETTLING.
REQ-035 Threshold boundary: baseline (0,0), accept (64,0) -> value=64, moving=0; then accept (0,65) -> value=129, moving=1.
REQ-036 Settle/re-trigger: in MOVING, 3 quiet samples then one with mag 200 -> stays moving=1; then 4 quiet samples -> moving=0 at the 4th sample's value_valid.
REQ-037 Saturation: baseline (-32768,-32768), accept (32767,32767) -> dx=dy=16'hFFFF, value=16'hFFFF.
REQ-038 Timeout/reset: in MOVING, hold sample_valid=0 for TIMEOUT cycles -> moving=0, next sample is baseline only; rst=0 mid-pipeline -> outputs at reset values immediately, no value_valid.

Source files
------------

// File: rtl/motion_detector.sv
// Two-axis motion detector: |dx|+|dy| against a baseline, drives a moving flag with settle hysteresis.
// Latency: value/moving/value_valid update two edges after acceptance; the first sample after IDLE only sets the baseline.
// Backpressure: sample_ready drops for the cycle after each acceptance, so at most one sample per two cycles.
module motion_detector #(
    parameter logic [15:0] THRESH         = 16'd64,
    parameter int unsigned SETTLE_SAMPLES = 4,
    parameter int unsigned TIMEOUT        = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    output logic        sample_ready,
    output logic [15:0] value,
    output logic        moving,
    output logic        value_valid
);

    typedef enum logic [1:0] {IDLE, STILL, MOVING, SETTLING} state_t;

    localparam logic [23:0] TIMEOUT_CNT = 24'(TIMEOUT);
    localparam logic [7:0]  SETTLE_CNT  = 8'(SETTLE_SAMPLES);

    // The signed difference always fits 17 bits, so its magnitude tops out at 16'hFFFF.
    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] d;
        logic [16:0] m;
        d = {a[15], a} - {b[15], b};
        m = d[16] ? (~d + 17'd1) : d;
        return m[16] ? 16'hFFFF : m[15:0];
    endfunction

    state_t      state;
    logic [15:0] prev_x, prev_y;
    logic [15:0] s_x, s_y;
    logic        p1_vld;
    logic [15:0] dx, dy;
    logic        p2_vld;
    logic [7:0]  quiet_cnt;
    logic [23:0] idle_cnt;
    logic        acc_d;

    logic        accept;
    logic        timeout;
    logic [16:0] mag_sum;
    logic [15:0] mag;
    logic        quiet;
    logic [7:0]  quiet_next;

    assign sample_ready = !acc_d;
    assign accept       = sample_valid && sample_ready;
    // An acceptance on the timeout edge keeps the detector alive.
    assign timeout      = (idle_cnt == TIMEOUT_CNT) && (state != IDLE) && !accept;
    assign mag_sum      = {1'b0, dx} + {1'b0, dy};
    assign mag          = mag_sum[16] ? 16'hFFFF : mag_sum[15:0];
    assign quiet        = (mag <= THRESH);
    assign quiet_next   = quiet_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            prev_x      <= '0;
            prev_y      <= '0;
            s_x         <= '0;
            s_y         <= '0;
            p1_vld      <= 1'b0;
            dx          <= '0;
            dy          <= '0;
            p2_vld      <= 1'b0;
            quiet_cnt   <= '0;
            idle_cnt    <= '0;
            acc_d       <= 1'b0;
            value       <= '0;
            moving      <= 1'b0;
            value_valid <= 1'b0;
        end else begin
            acc_d       <= accept;
            value_valid <= 1'b0;
            p1_vld      <= accept && (state != IDLE);
            p2_vld      <= p1_vld;

            if (accept)
                idle_cnt <= '0;
            else if (idle_cnt != TIMEOUT_CNT)
                idle_cnt <= idle_cnt + 24'd1;

            if (accept) begin
                s_x <= sample_x;
                s_y <= sample_y;
            end

            if (p1_vld && !timeout) begin
                dx     <= abs_diff(s_x, prev_x);
                dy     <= abs_diff(s_y, prev_y);
                prev_x <= s_x;
                prev_y <= s_y;
            end

            if (accept && state == IDLE) begin
                prev_x <= sample_x;
                prev_y <= sample_y;
                state  <= STILL;
            end

            if (timeout) begin
                state     <= IDLE;
                moving    <= 1'b0;
                quiet_cnt <= '0;
                p1_vld    <= 1'b0;
                p2_vld    <= 1'b0;
            end else if (p2_vld) begin
                value       <= mag;
                value_valid <= 1'b1;
                case (state)
                    STILL: begin
                        if (!quiet) begin
                            state  <= MOVING;
                            moving <= 1'b1;
                        end
                    end
                    MOVING: begin
                        if (quiet) begin
                            if (SETTLE_CNT == 8'd1) begin
                                state     <= STILL;
                                moving    <= 1'b0;
                                quiet_cnt <= '0;
                            end else begin
                                state     <= SETTLING;
                                quiet_cnt <= 8'd1;
                            end
                        end
                    end
                    SETTLING: begin
                        if (!quiet) begin
                            state     <= MOVING;
                            quiet_cnt <= '0;
                        end else if (quiet_next == SETTLE_CNT) begin
                            state     <= STILL;
                            moving    <= 1'b0;
                            quiet_cnt <= '0;
                        end else begin
                            quiet_cnt <= quiet_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motion_detector.sv
// Directed bench for motion_detector: baseline, threshold, settle hysteresis, saturation, timeout and reset.
module tb_motion_detector;

    logic        clk;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample_x;
    logic [15:0] sample_y;
    logic        sample_ready;
    logic [15:0] value;
    logic        moving;
    logic        value_valid;

    int checks   = 0;
    int failures = 0;

    motion_detector #(
        .THRESH        (16'd64),
        .SETTLE_SAMPLES(4),
        .TIMEOUT       (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample_x    (sample_x),
        .sample_y    (sample_y),
        .sample_ready(sample_ready),
        .value       (value),
        .moving      (moving),
        .value_valid (value_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst          = 1'b0;
        sample_valid = 1'b0;
        sample_x     = '0;
        sample_y     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Presents one sample and returns 1ns after the edge that accepted it.
    task automatic drive(input logic [15:0] x, input logic [15:0] y);
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) begin
            failures++;
            $display("FAIL drive_ready_wait: sample_ready stayed %0b, wanted 1", sample_ready);
        end
        sample_valid = 1'b1;
        sample_x     = x;
        sample_y     = y;
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    // Observes value_valid one, two and three edges after acceptance.
    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        output logic vv_early, output logic vv, output logic [15:0] val,
                        output logic mov, output logic vv_late);
        drive(x, y);
        @(posedge clk); #1 vv_early = value_valid;
        @(posedge clk); #1 begin vv = value_valid; val = value; mov = moving; end
        @(posedge clk); #1 vv_late = value_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0; sample_valid = 1'b0; sample_x = '0; sample_y = '0;
        #12;
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", sample_ready); end
        checks++; if (value !== 16'h0000) begin failures++; $display("FAIL reset_value: got %0h want 0", value); end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL reset_moving: got %0b want 0", moving); end
        checks++; if (value_valid !== 1'b0) begin failures++; $display("FAIL reset_vv: got %0b want 0", value_valid); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_baseline();
        logic e, v, l, m;
        logic [15:0] d;
        apply_reset();
        send(16'd100, 16'd100, e, v, d, m, l);
        checks++; if ({e, v, l} !== 3'b000) begin failures++; $display("FAIL baseline_no_pulse: got %b want 000", {e, v, l}); end
        checks++; if (m !== 1'b0) begin failures++; $display("FAIL baseline_moving: got %0b want 0", m); end
        send(16'd110, 16'd100, e, v, d, m, l);
        checks++; if ({e, v, l} !== 3'b010) begin failures++; $display("FAIL still_pulse: got %b want 010", {e, v, l}); end
        checks++; if (d !== 16'd10) begin failures++; $display("FAIL still_value: got %0d want 10", d); end
        checks++; if (m !== 1'b0) begin failures++; $display("FAIL still_moving: got %0b want 0", m); end
    endtask

    // Runs a baseline then a table of samples with expected value/moving.
    task automatic test_sequences();
        logic [15:0] xs [19];
        logic [15:0] ys [19];
        logic [15:0] ev [19];
        logic        em [19];
        logic        bl [19];
        logic e, v, l, m;
        logic [15:0] d;
        // trigger: (0,0) base, (50,20) -> 70 moving, (50,20) -> 0 still moving
        xs[0] = 16'd0;   ys[0] = 16'd0;   bl[0] = 1; ev[0] = 16'd0;   em[0] = 0;
        xs[1] = 16'd50;  ys[1] = 16'd20;  bl[1] = 0; ev[1] = 16'd70;  em[1] = 1;
        xs[2] = 16'd50;  ys[2] = 16'd20;  bl[2] = 0; ev[2] = 16'd0;   em[2] = 1;
        // threshold: (0,0) base, (64,0) quiet, (0,65) -> 129 moving
        xs[3] = 16'd0;   ys[3] = 16'd0;   bl[3] = 1; ev[3] = 16'd0;   em[3] = 0;
        xs[4] = 16'd64;  ys[4] = 16'd0;   bl[4] = 0; ev[4] = 16'd64;  em[4] = 0;
        xs[5] = 16'd0;   ys[5] = 16'd65;  bl[5] = 0; ev[5] = 16'd129; em[5] = 1;
        // settle / re-trigger
        xs[6] = 16'd0;   ys[6] = 16'd0;   bl[6] = 1; ev[6] = 16'd0;   em[6] = 0;
        xs[7] = 16'd200; ys[7] = 16'd0;   bl[7] = 0; ev[7] = 16'd200; em[7] = 1;
        for (int i = 8; i < 11; i++) begin xs[i] = 16'd200; ys[i] = 16'd0; bl[i] = 0; ev[i] = 16'd0; em[i] = 1; end
        xs[11] = 16'd200; ys[11] = 16'd200; bl[11] = 0; ev[11] = 16'd200; em[11] = 1;
        for (int i = 12; i < 16; i++) begin xs[i] = 16'd200; ys[i] = 16'd200; bl[i] = 0; ev[i] = 16'd0; em[i] = (i != 15); end
        // saturation: -32768 base, +32767 -> FFFF, -1 -> 32768+32768 saturates, mixed signs -> 32
        xs[16] = 16'h8000; ys[16] = 16'h8000; bl[16] = 1; ev[16] = 16'd0;    em[16] = 0;
        xs[17] = 16'h7FFF; ys[17] = 16'h7FFF; bl[17] = 0; ev[17] = 16'hFFFF; em[17] = 1;
        xs[18] = 16'hFFFF; ys[18] = 16'hFFFF; bl[18] = 0; ev[18] = 16'hFFFF; em[18] = 1;
        for (int i = 0; i < 19; i++) begin
            if (bl[i]) apply_reset();
            send(xs[i], ys[i], e, v, d, m, l);
            if (bl[i]) begin
                checks++; if ({e, v, l} !== 3'b000) begin failures++; $display("FAIL seq%0d_baseline_pulse: got %b want 000", i, {e, v, l}); end
            end else begin
                checks++; if ({e, v, l} !== 3'b010) begin failures++; $display("FAIL seq%0d_pulse: got %b want 010", i, {e, v, l}); end
                checks++; if (d !== ev[i]) begin failures++; $display("FAIL seq%0d_value: got %0h want %0h", i, d, ev[i]); end
                checks++; if (m !== em[i]) begin failures++; $display("FAIL seq%0d_moving: got %0b want %0b", i, m, em[i]); end
            end
        end
        send(16'hFFF0, 16'h0010, e, v, d, m, l);
        checks++; if (d !== 16'd32) begin failures++; $display("FAIL mixed_sign_value: got %0d want 32", d); end
        checks++; if (m !== 1'b1) begin failures++; $display("FAIL mixed_sign_settling: got %0b want 1", m); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        sample_valid = 1'b1; sample_x = 16'd5; sample_y = 16'd5;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (sample_ready !== ((i % 2) == 0)) begin
                failures++; $display("FAIL b2b_ready%0d: got %0b want %0b", i, sample_ready, (i % 2) == 0);
            end
            @(negedge clk);
        end
        sample_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic e, v, l, m;
        logic [15:0] d;
        logic seen;
        apply_reset();
        send(16'd0, 16'd0, e, v, d, m, l);
        send(16'd200, 16'd0, e, v, d, m, l);
        checks++; if (m !== 1'b1) begin failures++; $display("FAIL to_pre_moving: got %0b want 1", m); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1 seen |= value_valid; end
        checks++; if (moving !== 1'b1) begin failures++; $display("FAIL to_before_expiry: got %0b want 1", moving); end
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1 seen |= value_valid; end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL to_moving_cleared: got %0b want 0", moving); end
        checks++; if (value !== 16'd200) begin failures++; $display("FAIL to_value_held: got %0d want 200", value); end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL to_no_pulse: got %0b want 0", seen); end
        send(16'd500, 16'd500, e, v, d, m, l);
        checks++; if ({e, v, l} !== 3'b000) begin failures++; $display("FAIL to_rebaseline_pulse: got %b want 000", {e, v, l}); end
        send(16'd510, 16'd500, e, v, d, m, l);
        checks++; if (v !== 1'b1 || d !== 16'd10 || m !== 1'b0) begin
            failures++; $display("FAIL to_after_rebaseline: got vv=%0b val=%0d mov=%0b want vv=1 val=10 mov=0", v, d, m);
        end
    endtask

    task automatic test_reset_mid_pipeline();
        logic e, v, l, m;
        logic [15:0] d;
        logic seen;
        apply_reset();
        send(16'd0, 16'd0, e, v, d, m, l);
        send(16'd200, 16'd0, e, v, d, m, l);
        drive(16'd400, 16'd0);
        checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_low: got %0b want 0", sample_ready); end
        #2 rst = 1'b0;
        #1;
        checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %0b want 1", sample_ready); end
        checks++; if (value !== 16'h0000) begin failures++; $display("FAIL mid_rst_value: got %0h want 0", value); end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL mid_rst_moving: got %0b want 0", moving); end
        seen = value_valid;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1 seen |= value_valid; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_no_pulse: got %0b want 0", seen); end
        @(negedge clk);
        rst = 1'b1;
        send(16'd7, 16'd7, e, v, d, m, l);
        checks++; if ({e, v, l} !== 3'b000) begin failures++; $display("FAIL mid_rebaseline_pulse: got %b want 000", {e, v, l}); end
        send(16'd10, 16'd7, e, v, d, m, l);
        checks++; if (v !== 1'b1 || d !== 16'd3 || m !== 1'b0) begin
            failures++; $display("FAIL mid_after_reset: got vv=%0b val=%0d mov=%0b want vv=1 val=3 mov=0", v, d, m);
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_sequences();
        test_back_to_back();
        test_timeout();
        test_reset_mid_pipeline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, wanted completion", $time);
        $fatal(1);
    end

endmodule
